// File: rtl/matrix_stream_buffer.sv
// Result buffer: gathers (row, col) addressed elements in any order, then streams the
// matrix out byte-wise (MSB first) in row- or column-major order on a valid/ready handshake.
//   state    | meaning
//   S_IDLE   | waiting for start with a legal configuration
//   S_LOAD   | accepting element writes until every entry is present
//   S_READY  | matrix complete, waiting for data_request
//   S_STREAM | reading elements ahead into a 2-entry skid and sending bytes
module matrix_stream_buffer #(
  parameter int ELEM_WIDTH = 16,
  parameter int MAX_ROWS   = 32,
  parameter int MAX_COLS   = 32
) (
  input  logic                          inter_refclk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS):0]     cfg_rows,
  input  logic [$clog2(MAX_COLS):0]     cfg_cols,
  input  logic                          cfg_col_major,
  input  logic                          valid_data_in,
  input  logic [$clog2(MAX_ROWS)-1:0]   row_addr,
  input  logic [$clog2(MAX_COLS)-1:0]   col_addr,
  input  logic [ELEM_WIDTH-1:0]         matrix_element,
  input  logic                          data_request,
  input  logic                          byte_ready,
  output logic [7:0]                    byte_out,
  output logic                          valid_data_out,
  output logic                          last_byte,
  output logic                          compile_done,
  output logic                          busy,
  output logic                          dup_err,
  output logic                          range_err
);

  localparam int BYTES = ELEM_WIDTH / 8;
  localparam int RW    = $clog2(MAX_ROWS);
  localparam int CW    = $clog2(MAX_COLS);
  localparam int CNTW  = RW + CW + 1;
  localparam int DEPTH = MAX_ROWS * MAX_COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [RW:0]       rows_q, rows_d;
  logic [CW:0]       cols_q, cols_d;
  logic              col_major_q, col_major_d;
  logic [DEPTH-1:0]  bitmap_q, bitmap_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              dup_q, dup_d;
  logic              range_q, range_d;
  logic [RW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cptr_q, cptr_d;
  logic [CNTW-1:0]   issue_left_q, issue_left_d;
  logic [CNTW-1:0]   out_left_q, out_left_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic              skid_wr_q, skid_wr_d;
  logic              skid_rd_q, skid_rd_d;
  logic [BW-1:0]     byte_idx_q, byte_idx_d;

  logic [ELEM_WIDTH-1:0] mem_q  [DEPTH];
  logic [ELEM_WIDTH-1:0] skid_q [2];

  logic            cfg_ok, wr_in_range, wr_en, out_valid, xfer, last_idx, elem_done;
  logic            is_last, issue, r_last, c_last;
  logic [CNTW-1:0] total;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [ELEM_WIDTH-1:0] head;
  logic [7:0]      byte_sel;

  assign cfg_ok = (cfg_rows != '0) && (cfg_rows <= (RW+1)'(MAX_ROWS)) &&
                  (cfg_cols != '0) && (cfg_cols <= (CW+1)'(MAX_COLS));
  assign total       = CNTW'(rows_q) * CNTW'(cols_q);
  assign wr_in_range = ({1'b0, row_addr} < rows_q) && ({1'b0, col_addr} < cols_q);
  assign wr_addr     = AW'(row_addr) * AW'(MAX_COLS) + AW'(col_addr);
  assign rd_addr     = AW'(rptr_q) * AW'(MAX_COLS) + AW'(cptr_q);
  assign wr_en       = (state_q == S_LOAD) && valid_data_in && wr_in_range;

  assign out_valid = (state_q == S_STREAM) && (skid_cnt_q != 2'd0);
  assign xfer      = out_valid && byte_ready;
  assign last_idx  = (byte_idx_q == BW'(BYTES - 1));
  assign elem_done = xfer && last_idx;
  assign is_last   = out_valid && last_idx && (out_left_q == CNTW'(1));
  // Popping frees a slot in the same cycle, which keeps BYTES=1 streams bubble-free.
  assign issue  = (state_q == S_STREAM) && (issue_left_q != '0) &&
                  ((skid_cnt_q < 2'd2) || elem_done);
  assign r_last = (rptr_q == RW'(rows_q - 1'b1));
  assign c_last = (cptr_q == CW'(cols_q - 1'b1));

  always_comb begin
    head     = skid_q[skid_rd_q];
    byte_sel = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_idx_q == BW'(b)) byte_sel = head[ELEM_WIDTH-1-8*b -: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    col_major_d  = col_major_q;
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    dup_d        = dup_q;
    range_d      = range_q;
    rptr_d       = rptr_q;
    cptr_d       = cptr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    skid_cnt_d   = skid_cnt_q;
    skid_wr_d    = skid_wr_q;
    skid_rd_d    = skid_rd_q;
    byte_idx_d   = byte_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          state_d     = S_LOAD;
          rows_d      = cfg_rows;
          cols_d      = cfg_cols;
          col_major_d = cfg_col_major;
          bitmap_d    = '0;
          count_d     = '0;
          dup_d       = 1'b0;
          range_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (valid_data_in) begin
          if (!wr_in_range) begin
            range_d = 1'b1;
          end else if (bitmap_q[wr_addr]) begin
            dup_d = 1'b1;
          end else begin
            bitmap_d[wr_addr] = 1'b1;
            count_d           = count_q + 1'b1;
          end
        end
        if (count_q == total) state_d = S_READY;
      end
      S_READY: begin
        if (data_request) begin
          state_d      = S_STREAM;
          rptr_d       = '0;
          cptr_d       = '0;
          issue_left_d = total;
          out_left_d   = total;
          skid_cnt_d   = 2'd0;
          skid_wr_d    = 1'b0;
          skid_rd_d    = 1'b0;
          byte_idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (issue) begin
          issue_left_d = issue_left_q - 1'b1;
          skid_wr_d    = ~skid_wr_q;
          if (col_major_q) begin
            rptr_d = r_last ? '0 : rptr_q + 1'b1;
            if (r_last) cptr_d = c_last ? '0 : cptr_q + 1'b1;
          end else begin
            cptr_d = c_last ? '0 : cptr_q + 1'b1;
            if (c_last) rptr_d = r_last ? '0 : rptr_q + 1'b1;
          end
        end
        if (xfer) begin
          if (last_idx) begin
            byte_idx_d = '0;
            skid_rd_d  = ~skid_rd_q;
            out_left_d = out_left_q - 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        skid_cnt_d = skid_cnt_q + {1'b0, issue} - {1'b0, elem_done};
        if (xfer && is_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inter_refclk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      cols_q       <= '0;
      col_major_q  <= 1'b0;
      bitmap_q     <= '0;
      count_q      <= '0;
      dup_q        <= 1'b0;
      range_q      <= 1'b0;
      rptr_q       <= '0;
      cptr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      skid_cnt_q   <= 2'd0;
      skid_wr_q    <= 1'b0;
      skid_rd_q    <= 1'b0;
      byte_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      col_major_q  <= col_major_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      dup_q        <= dup_d;
      range_q      <= range_d;
      rptr_q       <= rptr_d;
      cptr_q       <= cptr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      skid_cnt_q   <= skid_cnt_d;
      skid_wr_q    <= skid_wr_d;
      skid_rd_q    <= skid_rd_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  // The skid entries double as the RAM read register, giving the 1-cycle read latency.
  always_ff @(posedge inter_refclk) begin
    if (wr_en) mem_q[wr_addr] <= matrix_element;
    if (issue) skid_q[skid_wr_q] <= mem_q[rd_addr];
  end

  assign valid_data_out = out_valid;
  assign byte_out       = out_valid ? byte_sel : 8'h00;
  assign last_byte      = is_last;
  assign compile_done   = (state_q == S_READY);
  assign busy           = (state_q != S_IDLE);
  assign dup_err        = dup_q;
  assign range_err      = range_q;

endmodule

// File: tb/tb_matrix_stream_buffer.sv
// Directed bench for matrix_stream_buffer; expected bytes are queued by the stimulus and
// popped by a negedge monitor on every transfer.
module tb_matrix_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_col_major, valid_data_in, data_request, byte_ready;
  logic [5:0]  cfg_rows, cfg_cols;
  logic [4:0]  row_addr, col_addr;
  logic [15:0] matrix_element;
  logic [7:0]  byte_out;
  logic        valid_data_out, last_byte, compile_done, busy, dup_err, range_err;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  bit mon_en = 1'b1;
  logic [8:0] sb[$];

  logic [15:0] rm [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102};
  logic [15:0] cm [6] = '{16'h0000, 16'h0100, 16'h0001, 16'h0101, 16'h0002, 16'h0102};
  logic [15:0] dm [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'hBBBB};
  bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  matrix_stream_buffer #(.ELEM_WIDTH(16), .MAX_ROWS(32), .MAX_COLS(32)) dut (
    .inter_refclk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols), .cfg_col_major(cfg_col_major), .valid_data_in(valid_data_in),
    .row_addr(row_addr), .col_addr(col_addr), .matrix_element(matrix_element),
    .data_request(data_request), .byte_ready(byte_ready), .byte_out(byte_out),
    .valid_data_out(valid_data_out), .last_byte(last_byte), .compile_done(compile_done),
    .busy(busy), .dup_err(dup_err), .range_err(range_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per transfer, and output must hold while stalled.
  logic [8:0] held;
  bit         stalled = 1'b0;
  always @(negedge clk) begin
    if (mon_en && valid_data_out) begin
      if (stalled) check("hold_while_stalled", {last_byte, byte_out}, held);
      if (byte_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %0h want none", byte_out);
        end else begin
          check("stream_byte", {last_byte, byte_out}, sb.pop_front());
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = {last_byte, byte_out};
      end
    end else begin
      if (mon_en && stalled) check("valid_dropped", valid_data_out, 1'b1);
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rows, input int cols, input bit colm);
    cfg_rows = 6'(rows); cfg_cols = 6'(cols); cfg_col_major = colm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic [15:0] v);
    valid_data_in = 1'b1; row_addr = 5'(r); col_addr = 5'(c); matrix_element = v;
    tick();
    valid_data_in = 1'b0;
  endtask

  task automatic load_all(input bit reverse);
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = reverse ? 5 - k : k;
      wr(idx / 3, idx % 3, 16'(16'h0100 * (idx / 3) + idx % 3));
    end
  endtask

  task automatic push_word(input logic [15:0] w, input bit last);
    sb.push_back({1'b0, w[15:8]});
    sb.push_back({last, w[7:0]});
  endtask

  task automatic push_tab(input logic [15:0] t [6]);
    for (int i = 0; i < 6; i++) push_word(t[i], i == 5);
  endtask

  task automatic request_and_drain(input bit bp, input int nbytes);
    xfer_cnt = 0;
    byte_ready = 1'b0;
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    check("compile_done_drop", compile_done, 1'b0);
    check("latency_cycle1", valid_data_out, 1'b0);
    tick();
    check("latency_cycle2", valid_data_out, 1'b1);
    for (int i = 0; i < 200 && busy; i++) begin
      byte_ready = bp ? bp_pat[i % 4] : 1'b1;
      tick();
    end
    byte_ready = 1'b0;
    check("stream_end_idle", busy, 1'b0);
    check("valid_after_last", valid_data_out, 1'b0);
    check("queue_drained", sb.size(), 0);
    check("xfer_count", xfer_cnt, nbytes);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_col_major = 1'b0;
    valid_data_in = 1'b0; row_addr = '0; col_addr = '0; matrix_element = '0;
    data_request = 1'b0; byte_ready = 1'b0;
    tick(); tick();
    check("rst_valid", valid_data_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", compile_done, 1'b0);
    check("rst_errs", {dup_err, range_err, last_byte}, 3'b000);
    check("rst_byte", byte_out, 8'h00);
    rst_n = 1'b1;
    tick();

    do_start(0, 3, 1'b0);
    check("illegal_rows0", busy, 1'b0);
    do_start(2, 33, 1'b0);
    check("illegal_cols33", busy, 1'b0);

    // 1: row-major, reverse write order
    do_start(2, 3, 1'b0);
    check("t1_busy", busy, 1'b1);
    load_all(1'b1);
    check("t1_not_ready_yet", compile_done, 1'b0);
    tick();
    check("t1_ready", compile_done, 1'b1);
    do_start(1, 1, 1'b0);
    check("t1_start_ignored", compile_done, 1'b1);
    push_tab(rm);
    request_and_drain(1'b0, 12);

    // 2: column-major
    do_start(2, 3, 1'b1);
    load_all(1'b1);
    tick();
    check("t2_ready", compile_done, 1'b1);
    push_tab(cm);
    request_and_drain(1'b0, 12);

    // 3: backpressure
    do_start(2, 3, 1'b0);
    load_all(1'b0);
    tick();
    push_tab(rm);
    request_and_drain(1'b1, 12);

    // 4: duplicate write to (1,2)
    do_start(2, 3, 1'b0);
    wr(1, 2, 16'hAAAA);
    wr(1, 2, 16'hBBBB);
    check("t4_dup_err", dup_err, 1'b1);
    wr(0, 0, 16'h0000); wr(0, 1, 16'h0001); wr(0, 2, 16'h0002); wr(1, 0, 16'h0100);
    tick();
    check("t4_count_not_inflated", compile_done, 1'b0);
    wr(1, 1, 16'h0101);
    tick();
    check("t4_ready", compile_done, 1'b1);
    push_tab(dm);
    request_and_drain(1'b0, 12);

    // 5: out-of-range write
    do_start(2, 3, 1'b0);
    check("t5_dup_cleared", dup_err, 1'b0);
    wr(2, 0, 16'hFFFF);
    check("t5_range_err", range_err, 1'b1);
    check("t5_still_load", {busy, compile_done}, 2'b10);
    load_all(1'b0);
    tick();
    check("t5_ready", compile_done, 1'b1);
    push_tab(rm);
    request_and_drain(1'b0, 12);

    // 6: reset mid-stream, then a 1x1 matrix
    do_start(2, 3, 1'b0);
    load_all(1'b0);
    tick();
    push_tab(rm);
    xfer_cnt = 0;
    data_request = 1'b1;
    tick();
    data_request = 1'b0;
    byte_ready = 1'b1;
    for (int i = 0; i < 50 && xfer_cnt < 5; i++) tick();
    check("t6_five_sent", xfer_cnt, 5);
    mon_en = 1'b0;
    byte_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", valid_data_out, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_last", last_byte, 1'b0);
    rst_n = 1'b1;
    sb.delete();
    mon_en = 1'b1;
    tick();
    do_start(1, 1, 1'b0);
    wr(0, 0, 16'h1234);
    tick();
    check("t6_ready", compile_done, 1'b1);
    push_word(16'h1234, 1'b1);
    request_and_drain(1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
